// File: rtl/kernel_cc_write_back.sv
// kernel_cc_write_back: drains the result FIFO to memory as incrementing write bursts, one job per start token
module kernel_cc_write_back #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 64,
   parameter int CNT_WIDTH  = 32,
   parameter int MAX_BURST  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_empty_n,
   output logic                  start_read,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  num_words,
   input  logic                  din_empty_n,
   output logic                  din_read,
   input  logic [DATA_WIDTH-1:0] din_dout,
   output logic                  aw_valid,
   input  logic                  aw_ready,
   output logic [ADDR_WIDTH-1:0] aw_addr,
   output logic [7:0]            aw_len,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic                  w_last,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [1:0]            b_resp,
   output logic                  done,
   output logic                  idle,
   output logic                  err
);
   localparam int BYTES = DATA_WIDTH / 8;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
   logic [7:0]            len_q, len_d;
   logic [7:0]            beat_cnt_q, beat_cnt_d;
   logic                  err_q, err_d;
   logic [8:0]            beats;
   logic [CNT_WIDTH-1:0]  rem_next;
   logic [CNT_WIDTH-1:0]  burst_src;
   logic [7:0]            len_new;

   // the burst length for the next AW comes from the fresh job count in IDLE, else from what is left after the B
   assign beats     = {1'b0, len_q} + 9'd1;
   assign rem_next  = remaining_q - CNT_WIDTH'(beats);
   assign burst_src = (state_q == IDLE) ? num_words : rem_next;
   assign len_new   = (burst_src < CNT_WIDTH'(MAX_BURST)) ? 8'(burst_src - CNT_WIDTH'(1)) : 8'(MAX_BURST - 1);

   assign start_read = (state_q == IDLE) & start_empty_n;
   assign aw_valid   = (state_q == ADDR);
   assign aw_addr    = cur_addr_q;
   assign aw_len     = len_q;
   assign w_valid    = (state_q == DATA) & din_empty_n;
   assign w_data     = (state_q == DATA) ? din_dout : '0;
   assign w_last     = (state_q == DATA) & (beat_cnt_q == len_q);
   assign din_read   = w_valid & w_ready;
   assign b_ready    = (state_q == RESP);
   assign done       = (state_q == DONE);
   assign idle       = (state_q == IDLE);
   assign err        = err_q;

   // next-state and datapath updates for the one-burst-outstanding write sequence
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      len_d       = len_q;
      beat_cnt_d  = beat_cnt_q;
      err_d       = err_q;
      case (state_q)
         IDLE: if (start_empty_n) begin
            cur_addr_d  = base_addr;
            remaining_d = num_words;
            err_d       = 1'b0;
            len_d       = len_new;
            state_d     = (num_words == '0) ? DONE : ADDR;
         end
         ADDR: if (aw_ready) begin
            beat_cnt_d = '0;
            state_d    = DATA;
         end
         DATA: if (din_read) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            state_d    = w_last ? RESP : DATA;
         end
         RESP: if (b_valid) begin
            err_d       = err_q | (b_resp != 2'b00);
            remaining_d = rem_next;
            cur_addr_d  = cur_addr_q + ADDR_WIDTH'(beats) * ADDR_WIDTH'(BYTES);
            len_d       = len_new;
            state_d     = (rem_next == '0) ? DONE : ADDR;
         end
         default: state_d = IDLE;
      endcase
   end

   // state register; reset abandons any burst in flight without a done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         len_q       <= '0;
         beat_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         len_q       <= len_d;
         beat_cnt_q  <= beat_cnt_d;
         err_q       <= err_d;
      end
   end
endmodule

// File: tb/tb_kernel_cc_write_back.sv
// tb_kernel_cc_write_back: scoreboard bench for the write-back burst master
module tb_kernel_cc_write_back;
   localparam int MAXB = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_empty_n;
   logic        start_read;
   logic [63:0] base_addr;
   logic [31:0] num_words;
   logic        din_empty_n;
   logic        din_read;
   logic [31:0] din_dout;
   logic        aw_valid;
   logic        aw_ready;
   logic [63:0] aw_addr;
   logic [7:0]  aw_len;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_data;
   logic        w_last;
   logic        b_valid;
   logic        b_ready;
   logic [1:0]  b_resp;
   logic        done;
   logic        idle;
   logic        err;

   kernel_cc_write_back #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .CNT_WIDTH(32), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset_n(reset_n), .start_empty_n(start_empty_n), .start_read(start_read),
      .base_addr(base_addr), .num_words(num_words), .din_empty_n(din_empty_n), .din_read(din_read),
      .din_dout(din_dout), .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last), .b_valid(b_valid),
      .b_ready(b_ready), .b_resp(b_resp), .done(done), .idle(idle), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   logic [31:0] fifo[$];
   logic [71:0] exp_aw[$];
   logic [32:0] exp_w[$];
   bit   stall = 0;
   int   err_at = -1;
   int   b_total = 0;
   int   cyc = 0;
   int   aw_cnt = 0, w_cnt = 0, rd_cnt = 0, done_cnt = 0, pop_cnt = 0;
   int   done_cyc = 0, pop_cyc = 0, b_cyc = 0;

   // memory/FIFO side: readies, FIFO head and B responses change just after each rising edge
   initial begin
      bit pop, bhs;
      aw_ready = 0; w_ready = 0; din_empty_n = 0; din_dout = 0; b_valid = 0; b_resp = 0;
      forever begin
         @(negedge clk);
         pop = din_read;
         bhs = b_valid & b_ready;
         @(posedge clk);
         #1;
         if (pop && fifo.size() > 0) void'(fifo.pop_front());
         if (bhs) b_total++;
         aw_ready    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         w_ready     = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         din_empty_n = (fifo.size() > 0) && !(stall && $urandom_range(0, 3) == 0);
         din_dout    = (fifo.size() > 0) ? fifo[0] : 32'h0;
         b_valid     = b_ready && (!stall || $urandom_range(0, 1) == 1);
         b_resp      = (b_total == err_at) ? 2'b10 : 2'b00;
      end
   end

   // scoreboard: AW and W handshakes are popped against expectations as they happen
   initial begin
      bit aw_stall;
      bit outstanding;
      logic [63:0] st_addr;
      logic [7:0]  st_len;
      logic [71:0] ea;
      logic [32:0] ew;
      aw_stall = 0; outstanding = 0; st_addr = 0; st_len = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            aw_stall = 0;
            outstanding = 0;
         end else begin
            if (aw_stall) begin
               n_cmp++;
               if (aw_valid !== 1'b1 || aw_addr !== st_addr || aw_len !== st_len) begin
                  n_fail++;
                  $display("FAIL aw_stable: got v=%0b addr=%h len=%0d, need v=1 addr=%h len=%0d", aw_valid, aw_addr, aw_len, st_addr, st_len);
               end
            end
            if (aw_valid && aw_ready) begin
               n_cmp++;
               if (exp_aw.size() == 0) begin
                  n_fail++;
                  $display("FAIL aw_unexpected: got addr=%h len=%0d, need no AW", aw_addr, aw_len);
               end else begin
                  ea = exp_aw.pop_front();
                  if ({aw_addr, aw_len} !== ea) begin
                     n_fail++;
                     $display("FAIL aw: got addr=%h len=%0d, need addr=%h len=%0d", aw_addr, aw_len, ea[71:8], ea[7:0]);
                  end
               end
               n_cmp++;
               if (outstanding) begin
                  n_fail++;
                  $display("FAIL aw_before_b: got AW with burst outstanding=1, need 0");
               end
               outstanding = 1;
               aw_cnt++;
            end
            aw_stall = aw_valid && !aw_ready;
            st_addr  = aw_addr;
            st_len   = aw_len;
            if (w_valid || din_read) begin
               n_cmp++;
               if (din_read !== (w_valid && w_ready)) begin
                  n_fail++;
                  $display("FAIL din_read: got %0b, need %0b", din_read, w_valid && w_ready);
               end
            end
            if (w_valid && w_ready) begin
               n_cmp++;
               if (exp_w.size() == 0) begin
                  n_fail++;
                  $display("FAIL w_unexpected: got data=%h last=%0b, need no beat", w_data, w_last);
               end else begin
                  ew = exp_w.pop_front();
                  if ({w_last, w_data} !== ew) begin
                     n_fail++;
                     $display("FAIL w: got data=%h last=%0b, need data=%h last=%0b", w_data, w_last, ew[31:0], ew[32]);
                  end
               end
               w_cnt++;
            end
            if (din_read) rd_cnt++;
            if (b_valid && b_ready) begin
               outstanding = 0;
               b_cyc = cyc;
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (start_read) begin
               pop_cnt++;
               pop_cyc = cyc;
            end
         end
         cyc++;
      end
   end

   task automatic prep_job(input logic [63:0] base, input int n);
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         d = $urandom;
         fifo.push_back(d);
         exp_w.push_back({((i % MAXB) == MAXB - 1) || (i == n - 1), d});
      end
      for (int o = 0; o < n; o += MAXB)
         exp_aw.push_back({base + 64'(o * 4), 8'(((n - o) < MAXB ? (n - o) : MAXB) - 1)});
   endtask

   task automatic run_job(input logic [63:0] base, input int n, input int err_k);
      int p0, d0, t;
      prep_job(base, n);
      err_at = (err_k < 0) ? -1 : b_total + err_k;
      p0 = pop_cnt;
      d0 = done_cnt;
      @(posedge clk);
      #2;
      base_addr = base;
      num_words = 32'(n);
      start_empty_n = 1;
      t = 0;
      while (pop_cnt == p0 && t < 20) begin
         @(posedge clk);
         t++;
      end
      #2;
      start_empty_n = 0;
      base_addr = {$urandom, $urandom};
      num_words = $urandom;
      n_cmp++;
      if (pop_cnt == p0) begin
         n_fail++;
         $display("FAIL pop_timeout: got no start_read in %0d cycles, need a pop", t);
      end
      n_cmp++;
      if ({aw_valid, done} !== {n != 0, n == 0}) begin
         n_fail++;
         $display("FAIL pop_latency: got aw_valid=%0b done=%0b, need %0b %0b", aw_valid, done, n != 0, n == 0);
      end
      t = 0;
      while (done_cnt == d0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      n_cmp++;
      if (done_cnt == d0) begin
         n_fail++;
         $display("FAIL done_timeout: got no done in %0d cycles, need one", t);
      end
      repeat (3) @(posedge clk);
      n_cmp++;
      if (done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL done_count: got %0d, need 1", done_cnt - d0);
      end
      n_cmp++;
      if (done_cyc != (n == 0 ? pop_cyc : b_cyc) + 1) begin
         n_fail++;
         $display("FAIL done_timing: got cycle %0d, need %0d", done_cyc, (n == 0 ? pop_cyc : b_cyc) + 1);
      end
      n_cmp++;
      if (exp_aw.size() != 0 || exp_w.size() != 0) begin
         n_fail++;
         $display("FAIL leftover: got aw=%0d w=%0d pending, need 0 0", exp_aw.size(), exp_w.size());
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      n_cmp++;
      if ({idle, start_read, din_read, aw_valid, w_valid, w_last, b_ready, done, err} !== 9'b1_0000_0000) begin
         n_fail++;
         $display("FAIL %s_flags: got %b, need 100000000", tag, {idle, start_read, din_read, aw_valid, w_valid, w_last, b_ready, done, err});
      end
      n_cmp++;
      if ({aw_addr, aw_len, w_data} !== '0) begin
         n_fail++;
         $display("FAIL %s_data: got addr=%h len=%0d wdata=%h, need 0", tag, aw_addr, aw_len, w_data);
      end
   endtask

   task automatic test_reset;
      check_reset_outputs("reset");
   endtask

   task automatic test_single;
      int a0 = aw_cnt, r0 = rd_cnt;
      run_job(64'h1000, 5, -1);
      n_cmp++;
      if (aw_cnt - a0 != 1 || rd_cnt - r0 != 5 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL single: got aw=%0d rd=%0d err=%0b, need 1 5 0", aw_cnt - a0, rd_cnt - r0, err);
      end
   endtask

   task automatic test_multi_burst;
      int a0 = aw_cnt, r0 = rd_cnt;
      run_job(64'h1000, 40, -1);
      n_cmp++;
      if (aw_cnt - a0 != 3 || rd_cnt - r0 != 40) begin
         n_fail++;
         $display("FAIL multi: got aw=%0d rd=%0d, need 3 40", aw_cnt - a0, rd_cnt - r0);
      end
   endtask

   task automatic test_zero;
      int a0 = aw_cnt, w0 = w_cnt;
      run_job(64'h2000, 0, -1);
      n_cmp++;
      if (aw_cnt != a0 || w_cnt != w0) begin
         n_fail++;
         $display("FAIL zero: got aw=%0d w=%0d, need 0 0", aw_cnt - a0, w_cnt - w0);
      end
   endtask

   task automatic test_stall;
      int w0 = w_cnt, r0 = rd_cnt, a0 = aw_cnt;
      stall = 1;
      run_job(64'h3000, 37, -1);
      stall = 0;
      n_cmp++;
      if (w_cnt - w0 != 37 || rd_cnt - r0 != 37 || aw_cnt - a0 != 3) begin
         n_fail++;
         $display("FAIL stall: got w=%0d rd=%0d aw=%0d, need 37 37 3", w_cnt - w0, rd_cnt - r0, aw_cnt - a0);
      end
   endtask

   task automatic test_err;
      run_job(64'h4000, 40, 1);
      n_cmp++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_set: got %0b, need 1", err);
      end
      run_job(64'h5000, 3, -1);
      n_cmp++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear: got %0b, need 0", err);
      end
   endtask

   task automatic test_back_to_back;
      int p0 = pop_cnt, d0 = done_cnt, t = 0;
      prep_job(64'h6000, 2);
      prep_job(64'h7000, 3);
      err_at = -1;
      @(posedge clk);
      #2;
      base_addr = 64'h6000;
      num_words = 2;
      start_empty_n = 1;
      while (pop_cnt == p0 && t < 20) begin
         @(posedge clk);
         t++;
      end
      #2;
      base_addr = 64'h7000;
      num_words = 3;
      while (pop_cnt < p0 + 2 && t < 500) begin
         @(posedge clk);
         t++;
      end
      #2;
      start_empty_n = 0;
      n_cmp++;
      if (pop_cnt != p0 + 2 || done_cnt != d0 + 1 || pop_cyc != done_cyc + 1) begin
         n_fail++;
         $display("FAIL b2b_gap: got pops=%0d dones=%0d pop@%0d done@%0d, need 2 1 and pop one cycle after done", pop_cnt - p0, done_cnt - d0, pop_cyc, done_cyc);
      end
      while (done_cnt < d0 + 2 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      repeat (2) @(posedge clk);
      n_cmp++;
      if (done_cnt != d0 + 2 || exp_aw.size() != 0 || exp_w.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_end: got dones=%0d pending aw=%0d w=%0d, need 2 0 0", done_cnt - d0, exp_aw.size(), exp_w.size());
      end
   endtask

   task automatic test_reset_mid;
      int w0 = w_cnt, d0, t = 0;
      prep_job(64'h8000, 10);
      err_at = -1;
      @(posedge clk);
      #2;
      base_addr = 64'h8000;
      num_words = 10;
      start_empty_n = 1;
      while (w_cnt < w0 + 3 && t < 200) begin
         @(posedge clk);
         if (start_read === 1'b0) start_empty_n = 0;
         t++;
      end
      #2;
      start_empty_n = 0;
      reset_n = 0;
      d0 = done_cnt;
      fifo.delete();
      exp_aw.delete();
      exp_w.delete();
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1;
      run_job(64'h9000, 4, -1);
      n_cmp++;
      if (done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL midreset_done: got %0d dones, need 1", done_cnt - d0);
      end
   endtask

   initial begin
      reset_n = 0;
      start_empty_n = 0;
      base_addr = 0;
      num_words = 0;
      repeat (3) @(posedge clk);
      #2;
      test_reset;
      reset_n = 1;
      repeat (2) @(posedge clk);
      test_single;
      test_multi_burst;
      test_zero;
      test_stall;
      test_err;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/kernel_cc_write_back.md
Name: kernel_cc_write_back

Overview:
- Dataflow stage that consumes the 1-bit start token produced by the write_back start FIFO.
- Drains a result-word FIFO and writes the words to external memory as incrementing bursts over a simplified AXI-style write master.
- One transaction per start token; pulses done on completion.
- Sits downstream of the start FIFO and the result FIFO, and upstream of the memory interconnect.

Parameters:
- DATA_WIDTH, 32, result word / W data width (multiple of 8).
- ADDR_WIDTH, 64, byte address width.
- CNT_WIDTH, 32, word count width.
- MAX_BURST, 16, max beats per burst (1..256).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_empty_n  in  1  start FIFO has a token.
- start_read  out  1  pop start token.
- base_addr  in  ADDR_WIDTH  byte address; sampled when the token pops.
- num_words  in  CNT_WIDTH  word count; sampled when the token pops.
- din_empty_n  in  1  result FIFO not empty.
- din_read  out  1  pop result word.
- din_dout  in  DATA_WIDTH  result FIFO head word.
- aw_valid  out  1 / aw_ready  in  1 / aw_addr  out  ADDR_WIDTH / aw_len  out  8  (beats-1).
- w_valid  out  1 / w_ready  in  1 / w_data  out  DATA_WIDTH / w_last  out  1.
- b_valid  in  1 / b_ready  out  1 / b_resp  in  2.
- done  out  1  one-cycle completion pulse.
- idle  out  1  high in IDLE.
- err  out  1  sticky; set if any b_resp != 0; cleared at next token pop.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All registered state cleared. Outputs: start_read=0, din_read=0, aw_valid=0, w_valid=0, w_last=0, b_ready=0, done=0, err=0, idle=1. aw_addr/aw_len/w_data are don't-care but reset to 0.
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE:
  - start_read = start_empty_n (combinational).
  - On pop: latch cur_addr=base_addr and remaining=num_words; clear err.
  - Next state: DONE if num_words==0, else ADDR.
- ADDR:
  - beats = min(remaining, MAX_BURST), registered on entry.
  - aw_valid=1, aw_addr=cur_addr, aw_len=beats-1.
  - aw_addr and aw_len stay stable while aw_valid=1 && !aw_ready.
  - On aw_ready: beat_cnt=0, go to DATA.
- DATA (zero-latency pass-through):
  - w_valid = din_empty_n; w_data = din_dout; din_read = din_empty_n & w_ready.
  - w_last = (beat_cnt==beats-1).
  - Each handshake increments beat_cnt. Handshake on w_last goes to RESP.
  - No word is popped without a W handshake. FIFO empty mid-burst deasserts w_valid with no data loss.
- RESP:
  - b_ready=1.
  - On b_valid: err |= (b_resp!=0); remaining -= beats; cur_addr += beats*(DATA_WIDTH/8), wrapping modulo 2^ADDR_WIDTH.
  - Next state: DONE if the new remaining==0, else ADDR.
- DONE: done=1 for exactly one cycle, then IDLE. A token present in that cycle is not popped until IDLE (min 1 idle cycle between jobs).
- One outstanding burst only: no AW is issued before the prior B. No 4KB-boundary splitting; software aligns buffers.
- Latency: token pop to aw_valid = 1 cycle. Last B to done = 1 cycle.
- reset_n asserted mid-transaction aborts immediately: state returns to IDLE, the partial burst is abandoned, and no done is issued.
- b_valid/w_ready outside RESP/DATA are ignored.

Test Plan:
- Token, base_addr=0x1000, num_words=5, MAX_BURST=16, all ready=1, FIFO full -> one AW (addr 0x1000, len 4); 5 W beats, w_last on the 5th; b_resp=0 -> done pulse 1 cycle after B; err=0.
- num_words=40, MAX_BURST=16 -> three AWs at 0x1000/len15, 0x1040/len15, 0x1080/len7. Each AW follows the prior B. Exactly 40 din_read pulses; single done.
- num_words=0 -> start_read pulse, then done next cycle. No AW/W activity.
- Random w_ready/aw_ready stalls and din_empty_n gaps over 37 words -> aw_addr/aw_len stable while stalled; data order preserved; din_read count == W handshakes == 37.
- Second burst returns b_resp=2'b10 -> err=1 after that B; done still pulses; err clears on the next token pop.
- reset_n low in DATA after 3 beats, then released and a new token applied -> idle=1 with all valids 0 during reset; fresh transaction starts from the new base_addr with beat_cnt=0.
